// File: rtl/fifo_flags_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fifo_flags_pkg
//  Purpose : Shared constants, status type and level helper for the flagged
//            synchronous FIFO and its storage array.
//  Rev     : 1.0  initial release
// ============================================================================
package fifo_flags_pkg;

    // Deepest FIFO the block is intended for (1 << 10 entries).
    localparam int FIFO_MAX_LOGSIZE  = 10;

    // Default geometry and flag thresholds.
    localparam int FIFO_DEF_LOGSIZE  = 4;
    localparam int FIFO_DEF_WIDTH    = 8;
    localparam int FIFO_DEF_AF_LEVEL = 12;
    localparam int FIFO_DEF_AE_LEVEL = 2;

    // Occupancy flags, all derived from the registered pointers.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    // Keeps a threshold inside its legal window so that a mis-set parameter
    // still yields a flag that can both assert and deassert.
    function automatic int clamp_level(input int lvl, input int lo, input int hi);
        if (lvl < lo) begin
            return lo;
        end
        if (lvl > hi) begin
            return hi;
        end
        return lvl;
    endfunction

endpackage : fifo_flags_pkg
`default_nettype wire

// File: rtl/fifo_flags_ram.sv
`default_nettype none
// ============================================================================
//  Module  : fifo_flags_ram
//  Purpose : Simple dual-port storage for the FIFO: one synchronous write
//            port and one asynchronous read port. Contents are never reset.
//  Rev     : 1.0  initial release
// ============================================================================
module fifo_flags_ram
    import fifo_flags_pkg::*;
#(
    parameter int LOGSIZE = FIFO_DEF_LOGSIZE,
    parameter int WIDTH   = FIFO_DEF_WIDTH
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [LOGSIZE-1:0] waddr_i,
    input  logic [WIDTH-1:0]   wdata_i,
    input  logic [LOGSIZE-1:0] raddr_i,
    output logic [WIDTH-1:0]   rdata_o
);

    localparam int SIZE = 1 << LOGSIZE;

    logic [WIDTH-1:0] mem_q [SIZE];

    // Write port: capture data on an accepted write.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port is combinational so show-ahead mode sees the head directly.
    assign rdata_o = mem_q[raddr_i];

endmodule : fifo_flags_ram
`default_nettype wire

// File: rtl/fifo_flags.sv
`default_nettype none
// ============================================================================
//  Module  : fifo_flags
//  Purpose : Single-clock FIFO using all 2**LOGSIZE entries (extra pointer
//            bit), with occupancy count, programmable almost-full/empty
//            flags, show-ahead or registered read, and sticky over/underflow.
//  Rev     : 1.0  initial release
// ============================================================================
module fifo_flags
    import fifo_flags_pkg::*;
#(
    parameter int LOGSIZE   = FIFO_DEF_LOGSIZE,
    parameter int WIDTH     = FIFO_DEF_WIDTH,
    parameter int AF_LEVEL  = FIFO_DEF_AF_LEVEL,
    parameter int AE_LEVEL  = FIFO_DEF_AE_LEVEL,
    parameter int SHOWAHEAD = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             dout_valid_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic [LOGSIZE:0] count_o,
    input  logic             clr_err_i,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int SIZE = 1 << LOGSIZE;
    localparam int PW   = LOGSIZE + 1;

    // Thresholds held at pointer width so the level compares are exact.
    localparam logic [LOGSIZE:0] c_af_level = PW'(clamp_level(AF_LEVEL, 1, SIZE));
    localparam logic [LOGSIZE:0] c_ae_level = PW'(clamp_level(AE_LEVEL, 0, SIZE - 1));

    // Pointers carry one extra bit so full and empty are distinguishable
    // without giving up a storage slot.
    logic [LOGSIZE:0] wptr_q, wptr_d;
    logic [LOGSIZE:0] rptr_q, rptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic [LOGSIZE:0] w_count;
    fifo_status_t     w_status;
    logic             w_rd_accept;
    logic             w_wr_accept;
    logic [WIDTH-1:0] w_rdata;

    // Occupancy and flags come straight from the registered pointers, so
    // they change only in the cycle after the edge that moved a pointer.
    always_comb begin
        w_count               = wptr_q - rptr_q;
        w_status              = '0;
        w_status.empty        = (wptr_q == rptr_q);
        w_status.full         = (wptr_q[LOGSIZE-1:0] == rptr_q[LOGSIZE-1:0]) &&
                                (wptr_q[LOGSIZE] != rptr_q[LOGSIZE]);
        w_status.almost_full  = (w_count >= c_af_level);
        w_status.almost_empty = (w_count <= c_ae_level);
    end

    // Accept decisions: a write into a full FIFO still goes through when the
    // same cycle pops the head, since the freed slot is the one written.
    always_comb begin
        w_rd_accept = rd_i && !w_status.empty;
        w_wr_accept = wr_i && (!w_status.full || w_rd_accept);
    end

    // Next-state for pointers and sticky errors; a new error event wins
    // over a clear arriving in the same cycle.
    always_comb begin
        wptr_d      = wptr_q + PW'(w_wr_accept);
        rptr_d      = rptr_q + PW'(w_rd_accept);
        overflow_d  = (wr_i && !w_wr_accept) || (overflow_q && !clr_err_i);
        underflow_d = (rd_i && !w_rd_accept) || (underflow_q && !clr_err_i);
    end

    // State register; reset overrides any request in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_flags_ram #(
        .LOGSIZE (LOGSIZE),
        .WIDTH   (WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (w_wr_accept),
        .waddr_i (wptr_q[LOGSIZE-1:0]),
        .wdata_i (din_i),
        .raddr_i (rptr_q[LOGSIZE-1:0]),
        .rdata_o (w_rdata)
    );

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            // Head entry is always presented; it is valid whenever stored.
            assign dout_o       = w_rdata;
            assign dout_valid_o = !w_status.empty;
        end else begin : g_registered
            logic [WIDTH-1:0] dout_q, dout_d;
            logic             dv_q, dv_d;

            // Load the head on an accepted read, otherwise hold the last word.
            always_comb begin
                dout_d = dout_q;
                dv_d   = w_rd_accept;
                if (w_rd_accept) begin
                    dout_d = w_rdata;
                end
            end

            // Output register giving one-cycle read latency.
            always_ff @(posedge clk) begin
                if (reset) begin
                    dout_q <= '0;
                    dv_q   <= 1'b0;
                end else begin
                    dout_q <= dout_d;
                    dv_q   <= dv_d;
                end
            end

            assign dout_o       = dout_q;
            assign dout_valid_o = dv_q;
        end
    endgenerate

    assign full_o         = w_status.full;
    assign empty_o        = w_status.empty;
    assign almost_full_o  = w_status.almost_full;
    assign almost_empty_o = w_status.almost_empty;
    assign count_o        = w_count;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule : fifo_flags
`default_nettype wire

// File: tb/tb_fifo_flags.sv
`default_nettype none
// ============================================================================
//  Module  : tb_fifo_flags
//  Purpose : Directed self-checking bench for fifo_flags. Two instances share
//            the same stimulus: one show-ahead, one registered-read.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_flags;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr;
    logic       rd;
    logic       clr_err;
    logic [7:0] din;

    logic [7:0] sa_dout, rg_dout;
    logic       sa_dv, rg_dv;
    logic       sa_full, sa_empty, sa_af, sa_ae;
    logic       rg_full, rg_empty, rg_af, rg_ae;
    logic [2:0] sa_count, rg_count;
    logic       sa_ov, sa_uf, rg_ov, rg_uf;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fifo_flags #(.LOGSIZE(2), .WIDTH(8), .AF_LEVEL(3), .AE_LEVEL(1), .SHOWAHEAD(1)) u_dut_sa (
        .clk(clk), .reset(reset), .wr_i(wr), .din_i(din), .rd_i(rd),
        .dout_o(sa_dout), .dout_valid_o(sa_dv), .full_o(sa_full), .empty_o(sa_empty),
        .almost_full_o(sa_af), .almost_empty_o(sa_ae), .count_o(sa_count),
        .clr_err_i(clr_err), .overflow_o(sa_ov), .underflow_o(sa_uf)
    );

    fifo_flags #(.LOGSIZE(2), .WIDTH(8), .AF_LEVEL(3), .AE_LEVEL(1), .SHOWAHEAD(0)) u_dut_rg (
        .clk(clk), .reset(reset), .wr_i(wr), .din_i(din), .rd_i(rd),
        .dout_o(rg_dout), .dout_valid_o(rg_dv), .full_o(rg_full), .empty_o(rg_empty),
        .almost_full_o(rg_af), .almost_empty_o(rg_ae), .count_o(rg_count),
        .clr_err_i(clr_err), .overflow_o(rg_ov), .underflow_o(rg_uf)
    );

    // One clock: inputs applied at a falling edge, rising edge acts, and the
    // next falling edge is where results are observed.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        wr  = w;
        din = d;
        rd  = r;
        @(negedge clk);
        wr  = 1'b0;
        rd  = 1'b0;
        din = 8'h00;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        tests++; if (sa_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", sa_count); end
        tests++; if ({sa_full, sa_empty, sa_af, sa_ae} !== 4'b0101) begin fails++; $display("FAIL reset_flags got %b want 0101", {sa_full, sa_empty, sa_af, sa_ae}); end
        tests++; if ({sa_ov, sa_uf} !== 2'b00) begin fails++; $display("FAIL reset_err got %b want 00", {sa_ov, sa_uf}); end
        tests++; if ({sa_dv, rg_dv} !== 2'b00) begin fails++; $display("FAIL reset_valid got %b want 00", {sa_dv, rg_dv}); end
        tests++; if (rg_dout !== 8'h00) begin fails++; $display("FAIL reset_rg_dout got %h want 00", rg_dout); end
        tests++; if ({rg_count, rg_full, rg_empty, rg_af, rg_ae} !== {3'd0, 4'b0101}) begin fails++; $display("FAIL reset_rg_state got %b want 0000101", {rg_count, rg_full, rg_empty, rg_af, rg_ae}); end
    endtask

    task automatic test_fill;
        logic [7:0] data   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [3:0] exp_st [4] = '{4'b0001, 4'b0000, 4'b0010, 4'b1010};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, data[i], 1'b0);
            tests++; if (sa_count !== 3'(i + 1)) begin fails++; $display("FAIL fill_count[%0d] got %0d want %0d", i, sa_count, i + 1); end
            tests++; if ({sa_full, sa_empty, sa_af, sa_ae} !== exp_st[i]) begin fails++; $display("FAIL fill_flags[%0d] got %b want %b", i, {sa_full, sa_empty, sa_af, sa_ae}, exp_st[i]); end
            tests++; if (sa_ov !== 1'b0) begin fails++; $display("FAIL fill_overflow[%0d] got %b want 0", i, sa_ov); end
        end
        tests++; if (sa_dout !== 8'h11) begin fails++; $display("FAIL fill_head got %h want 11", sa_dout); end
    endtask

    task automatic test_overflow_drain;
        logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        cyc(1'b1, 8'h55, 1'b0);
        tests++; if ({sa_ov, sa_count} !== {1'b1, 3'd4}) begin fails++; $display("FAIL ovf_state got ov=%b cnt=%0d want ov=1 cnt=4", sa_ov, sa_count); end
        tests++; if (sa_dout !== 8'h11) begin fails++; $display("FAIL ovf_head got %h want 11", sa_dout); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (sa_dout !== exp_d[i]) begin fails++; $display("FAIL drain_sa[%0d] got %h want %h", i, sa_dout, exp_d[i]); end
            cyc(1'b0, 8'h00, 1'b1);
            tests++; if ({rg_dv, rg_dout} !== {1'b1, exp_d[i]}) begin fails++; $display("FAIL drain_rg[%0d] got v=%b d=%h want v=1 d=%h", i, rg_dv, rg_dout, exp_d[i]); end
            tests++; if (sa_count !== 3'(3 - i)) begin fails++; $display("FAIL drain_count[%0d] got %0d want %0d", i, sa_count, 3 - i); end
        end
        tests++; if ({sa_full, sa_empty, sa_af, sa_ae, sa_dv, sa_uf} !== 6'b010100) begin fails++; $display("FAIL drain_end got %b want 010100", {sa_full, sa_empty, sa_af, sa_ae, sa_dv, sa_uf}); end
    endtask

    task automatic test_full_wr_rd;
        logic [7:0] exp_d [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
        do_reset();
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b1, 8'h22, 1'b0);
        cyc(1'b1, 8'h33, 1'b0);
        cyc(1'b1, 8'h44, 1'b0);
        tests++; if ({sa_full, sa_count} !== {1'b1, 3'd4}) begin fails++; $display("FAIL fwr_prefill got full=%b cnt=%0d want full=1 cnt=4", sa_full, sa_count); end
        cyc(1'b1, 8'h66, 1'b1);
        tests++; if ({sa_full, sa_count, sa_ov} !== {1'b1, 3'd4, 1'b0}) begin fails++; $display("FAIL fwr_state got full=%b cnt=%0d ov=%b want full=1 cnt=4 ov=0", sa_full, sa_count, sa_ov); end
        tests++; if ({rg_dv, rg_dout} !== {1'b1, 8'h11}) begin fails++; $display("FAIL fwr_popped got v=%b d=%h want v=1 d=11", rg_dv, rg_dout); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (sa_dout !== exp_d[i]) begin fails++; $display("FAIL fwr_drain[%0d] got %h want %h", i, sa_dout, exp_d[i]); end
            cyc(1'b0, 8'h00, 1'b1);
        end
        tests++; if ({sa_empty, sa_ov, sa_uf} !== 3'b100) begin fails++; $display("FAIL fwr_end got %b want 100", {sa_empty, sa_ov, sa_uf}); end
    endtask

    task automatic test_empty_wr_rd;
        cyc(1'b1, 8'h77, 1'b1);
        tests++; if ({sa_uf, sa_ov, sa_count} !== {1'b1, 1'b0, 3'd1}) begin fails++; $display("FAIL ewr_state got uf=%b ov=%b cnt=%0d want uf=1 ov=0 cnt=1", sa_uf, sa_ov, sa_count); end
        tests++; if ({sa_dv, sa_dout} !== {1'b1, 8'h77}) begin fails++; $display("FAIL ewr_dout got v=%b d=%h want v=1 d=77", sa_dv, sa_dout); end
        tests++; if (rg_dv !== 1'b0) begin fails++; $display("FAIL ewr_rg_valid got %b want 0", rg_dv); end
        clr_err = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        clr_err = 1'b0;
        tests++; if ({sa_ov, sa_uf} !== 2'b00) begin fails++; $display("FAIL clr_err got %b want 00", {sa_ov, sa_uf}); end
        cyc(1'b0, 8'h00, 1'b1);
        clr_err = 1'b1;
        cyc(1'b0, 8'h00, 1'b1);
        clr_err = 1'b0;
        tests++; if ({sa_uf, sa_empty} !== 2'b11) begin fails++; $display("FAIL set_over_clr got uf=%b empty=%b want uf=1 empty=1", sa_uf, sa_empty); end
        clr_err = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        clr_err = 1'b0;
        tests++; if (sa_uf !== 1'b0) begin fails++; $display("FAIL clr_after_set got %b want 0", sa_uf); end
    endtask

    task automatic test_registered_read;
        do_reset();
        cyc(1'b1, 8'hA1, 1'b0);
        cyc(1'b1, 8'hA2, 1'b0);
        tests++; if (rg_dv !== 1'b0) begin fails++; $display("FAIL reg_idle_valid got %b want 0", rg_dv); end
        cyc(1'b0, 8'h00, 1'b1);
        tests++; if ({rg_dv, rg_dout} !== {1'b1, 8'hA1}) begin fails++; $display("FAIL reg_rd1 got v=%b d=%h want v=1 d=a1", rg_dv, rg_dout); end
        cyc(1'b0, 8'h00, 1'b1);
        tests++; if ({rg_dv, rg_dout} !== {1'b1, 8'hA2}) begin fails++; $display("FAIL reg_rd2 got v=%b d=%h want v=1 d=a2", rg_dv, rg_dout); end
        cyc(1'b0, 8'h00, 1'b0);
        tests++; if ({rg_dv, rg_dout} !== {1'b0, 8'hA2}) begin fails++; $display("FAIL reg_hold got v=%b d=%h want v=0 d=a2", rg_dv, rg_dout); end
        tests++; if ({rg_count, rg_empty} !== {3'd0, 1'b1}) begin fails++; $display("FAIL reg_empty got cnt=%0d empty=%b want cnt=0 empty=1", rg_count, rg_empty); end
    endtask

    task automatic test_wrap_reset;
        logic [7:0] exp_v;
        logic [7:0] post [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        do_reset();
        cyc(1'b0, 8'h00, 1'b1);
        tests++; if (sa_uf !== 1'b1) begin fails++; $display("FAIL wrap_pre_uf got %b want 1", sa_uf); end
        for (int i = 0; i < 10; i++) begin
            exp_v = 8'(8'h80 + i);
            cyc(1'b1, exp_v, (i != 0));
            tests++; if ({sa_count, sa_dout} !== {3'd1, exp_v}) begin fails++; $display("FAIL wrap[%0d] got cnt=%0d d=%h want cnt=1 d=%h", i, sa_count, sa_dout, exp_v); end
        end
        tests++; if (sa_uf !== 1'b1) begin fails++; $display("FAIL wrap_sticky got %b want 1", sa_uf); end
        reset = 1'b1;
        cyc(1'b1, 8'hEE, 1'b1);
        reset = 1'b0;
        tests++; if ({sa_count, sa_full, sa_empty, sa_af, sa_ae} !== {3'd0, 4'b0101}) begin fails++; $display("FAIL midreset_state got %b want 0000101", {sa_count, sa_full, sa_empty, sa_af, sa_ae}); end
        tests++; if ({sa_ov, sa_uf, rg_dv, rg_dout} !== 11'd0) begin fails++; $display("FAIL midreset_err got %b want 0", {sa_ov, sa_uf, rg_dv, rg_dout}); end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, post[i], 1'b0);
        end
        tests++; if ({sa_full, sa_count, sa_ov} !== {1'b1, 3'd4, 1'b0}) begin fails++; $display("FAIL post_fill got full=%b cnt=%0d ov=%b want full=1 cnt=4 ov=0", sa_full, sa_count, sa_ov); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (sa_dout !== post[i]) begin fails++; $display("FAIL post_sa[%0d] got %h want %h", i, sa_dout, post[i]); end
            cyc(1'b0, 8'h00, 1'b1);
            tests++; if ({rg_dv, rg_dout} !== {1'b1, post[i]}) begin fails++; $display("FAIL post_rg[%0d] got v=%b d=%h want v=1 d=%h", i, rg_dv, rg_dout, post[i]); end
        end
        tests++; if ({sa_empty, sa_uf} !== 2'b10) begin fails++; $display("FAIL post_end got %b want 10", {sa_empty, sa_uf}); end
    endtask

    initial begin
        reset   = 1'b1;
        wr      = 1'b0;
        rd      = 1'b0;
        clr_err = 1'b0;
        din     = 8'h00;
        @(negedge clk);
        test_reset();
        test_fill();
        test_overflow_drain();
        test_full_wr_rd();
        test_empty_wr_rd();
        test_registered_read();
        test_wrap_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog expired after 100000 ns");
        $fatal(1, "watchdog");
    end

endmodule : tb_fifo_flags
`default_nettype wire
